alu_issue: RTL and testbench

- ID/EX issue stage of the core. Decodes the instruction held in ID into the 4-bit ALU operation code and selects the two ALU operands.
- Captures both in a stall/flush-capable pipeline register and drives the EX-stage `alu` inputs (`alu_ctrl`, `op_A`, `op_B`).
- It is the producer end of the ALU interface: everything `alu` consumes is generated here, one cycle after ID handshake.

---
 rtl/alu_issue_if.sv | 34 +++
 rtl/alu_issue.sv | 143 ++++++++++++++
 tb/tb_alu_issue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: ID-to-EX issue bundle carrying the ID handshake, forwarding sources and ALU operands.
interface alu_issue_if #(parameter int XLEN = 32);
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic            ex_stall;
  logic            ex_flush;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic [XLEN-1:0] mem_fwd_data;
  logic [XLEN-1:0] wb_fwd_data;
  logic            ex_valid;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_A;
  logic [XLEN-1:0] op_B;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_pc_plus4;
  logic            ex_illegal;
  modport master (
    output id_valid, id_pc, id_inst, id_imm, id_rs1_data, id_rs2_data,
           ex_stall, ex_flush, fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
    input  id_ready, ex_valid, alu_ctrl, op_A, op_B, ex_store_data, ex_pc, ex_pc_plus4, ex_illegal
  );
  modport slave (
    input  id_valid, id_pc, id_inst, id_imm, id_rs1_data, id_rs2_data,
           ex_stall, ex_flush, fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
    output id_ready, ex_valid, alu_ctrl, op_A, op_B, ex_store_data, ex_pc, ex_pc_plus4, ex_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: ID/EX issue stage, decodes the ALU op, registers operands, forwards after the register.
// Define MATRIX_MUL_EN to decode custom-0 as MATRIX_MUL instead of an illegal instruction.
module alu_issue #(parameter int XLEN = 32) (
  input logic clk,
  input logic rstn,
  alu_issue_if.slave bus
);
  localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_SLL = 4'h2, ALU_SLT = 4'h3,
                         ALU_SLTU = 4'h4, ALU_XOR = 4'h5, ALU_SRL = 4'h6, ALU_SRA = 4'h7,
                         ALU_OR = 4'h8, ALU_AND = 4'h9, ALU_NOTEQ = 4'hA, ALU_SGE = 4'hB,
                         ALU_SGEU = 4'hC, ALU_JUMP = 4'hD, ALU_MATRIX_MUL = 4'hE, ALU_NOP = 4'hF;
  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OP_IMM = 7'b0010011, OPC_BRANCH = 7'b1100011,
                         OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_CUSTOM0 = 7'b0001011;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_src_e;
  typedef enum logic {B_RS2, B_IMM} b_src_e;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       b30;
  logic [3:0] dec_ctrl;
  a_src_e     dec_a;
  b_src_e     dec_b;
  logic       dec_ill;
  logic            valid_d, valid_q, ill_d, ill_q;
  logic [3:0]      ctrl_d, ctrl_q;
  a_src_e          a_sel_d, a_sel_q;
  b_src_e          b_sel_d, b_sel_q;
  logic [XLEN-1:0] pc_d, pc_q, pc4_d, pc4_q, rs1_d, rs1_q, rs2_d, rs2_q, imm_d, imm_q;
  logic [XLEN-1:0] fwd_a, fwd_b;
  assign opc = bus.id_inst[6:0];
  assign f3  = bus.id_inst[14:12];
  assign b30 = bus.id_inst[30];
  always_comb begin
    dec_ctrl = ALU_NOP;
    dec_a    = A_RS1;
    dec_b    = B_RS2;
    dec_ill  = 1'b0;
    case (opc)
      OPC_OP, OPC_OP_IMM: begin
        case (f3)
          3'b000:  dec_ctrl = (opc == OPC_OP && b30) ? ALU_SUB : ALU_ADD;
          3'b001:  dec_ctrl = ALU_SLL;
          3'b010:  dec_ctrl = ALU_SLT;
          3'b011:  dec_ctrl = ALU_SLTU;
          3'b100:  dec_ctrl = ALU_XOR;
          3'b101:  dec_ctrl = b30 ? ALU_SRA : ALU_SRL;
          3'b110:  dec_ctrl = ALU_OR;
          default: dec_ctrl = ALU_AND;
        endcase
        dec_b = (opc == OPC_OP_IMM) ? B_IMM : B_RS2;
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000:  dec_ctrl = ALU_SUB;
          3'b001:  dec_ctrl = ALU_NOTEQ;
          3'b100:  dec_ctrl = ALU_SLT;
          3'b101:  dec_ctrl = ALU_SGE;
          3'b110:  dec_ctrl = ALU_SLTU;
          3'b111:  dec_ctrl = ALU_SGEU;
          default: dec_ill  = 1'b1;
        endcase
      end
      OPC_JAL:              begin dec_ctrl = ALU_JUMP; dec_a = A_PC;   dec_b = B_IMM; end
      OPC_JALR:             begin dec_ctrl = ALU_JUMP; dec_b = B_IMM; end
      OPC_LOAD, OPC_STORE:  begin dec_ctrl = ALU_ADD;  dec_b = B_IMM; end
      OPC_LUI:              begin dec_ctrl = ALU_ADD;  dec_a = A_ZERO; dec_b = B_IMM; end
      OPC_AUIPC:            begin dec_ctrl = ALU_ADD;  dec_a = A_PC;   dec_b = B_IMM; end
`ifdef MATRIX_MUL_EN
      OPC_CUSTOM0:          dec_ctrl = ALU_MATRIX_MUL;
`endif
      default:              dec_ill = 1'b1;
    endcase
  end
  // Flush wins over stall and capture; an idle unstalled cycle loads a bubble.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    a_sel_d = a_sel_q;
    b_sel_d = b_sel_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    if (bus.ex_flush) begin
      valid_d = 1'b0;
      ctrl_d  = ALU_NOP;
    end else if (!bus.ex_stall) begin
      valid_d = bus.id_valid;
      ctrl_d  = bus.id_valid ? dec_ctrl : ALU_NOP;
      if (bus.id_valid) begin
        ill_d   = dec_ill;
        a_sel_d = dec_a;
        b_sel_d = dec_b;
        pc_d    = bus.id_pc;
        pc4_d   = bus.id_pc + 32'd4;
        rs1_d   = bus.id_rs1_data;
        rs2_d   = bus.id_rs2_data;
        imm_d   = bus.id_imm;
      end
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      ctrl_q  <= ALU_NOP;
      ill_q   <= 1'b0;
      a_sel_q <= A_RS1;
      b_sel_q <= B_RS2;
      pc_q    <= '0;
      pc4_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
    end
  end
  always_comb begin
    fwd_a = bus.fwd_a_sel == 2'd1 ? bus.mem_fwd_data : bus.fwd_a_sel == 2'd2 ? bus.wb_fwd_data : rs1_q;
    fwd_b = bus.fwd_b_sel == 2'd1 ? bus.mem_fwd_data : bus.fwd_b_sel == 2'd2 ? bus.wb_fwd_data : rs2_q;
  end
  assign bus.id_ready      = !bus.ex_stall;
  assign bus.ex_valid      = valid_q;
  assign bus.alu_ctrl      = valid_q ? ctrl_q : ALU_NOP;
  assign bus.ex_illegal    = valid_q & ill_q;
  assign bus.op_A          = !valid_q ? '0 : a_sel_q == A_PC ? pc_q : a_sel_q == A_ZERO ? '0 : fwd_a;
  assign bus.op_B          = !valid_q ? '0 : b_sel_q == B_IMM ? imm_q : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_pc_plus4   = pc4_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed-vector bench for alu_issue; compares {ex_valid, alu_ctrl, op_A, op_B} and side outputs.
module tb_alu_issue;
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, SRA = 4'h7, NOTEQ = 4'hA, JUMP = 4'hD,
                         MMUL = 4'hE, NOP = 4'hF;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  alu_issue_if bus();
  alu_issue dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
    bus.id_valid = v; bus.id_inst = inst; bus.id_pc = pc;
    bus.id_imm = imm; bus.id_rs1_data = rs1; bus.id_rs2_data = rs2;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B, bus.id_ready, bus.ex_pc_plus4, bus.ex_illegal} !== {1'b0, NOP, 64'd0, 1'b1, 32'd0, 1'b0}) begin
        n_err++;
        $display("FAIL reset cycle %0d: got %h want %h", i, {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B, bus.id_ready, bus.ex_pc_plus4, bus.ex_illegal}, {1'b0, NOP, 64'd0, 1'b1, 32'd0, 1'b0});
      end
      if (i == 4) rstn = 1'b1;
    end
  endtask
  task automatic test_add_sub();
    drive(1'b1, 32'h00000033, 32'h0, 32'h0, 32'd5, 32'd7);
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B} !== {1'b1, ADD, 32'd5, 32'd7}) begin
      n_err++;
      $display("FAIL add: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B}, {1'b1, ADD, 32'd5, 32'd7});
    end
    drive(1'b1, 32'h40000033, 32'h0, 32'h0, 32'd5, 32'd7);
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B} !== {1'b1, SUB, 32'd5, 32'd7}) begin
      n_err++;
      $display("FAIL sub: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B}, {1'b1, SUB, 32'd5, 32'd7});
    end
  endtask
  task automatic test_bne_fwd();
    drive(1'b1, 32'h00001063, 32'h0, 32'h0, 32'd3, 32'd3);
    bus.fwd_a_sel = 2'd1; bus.mem_fwd_data = 32'd9;
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B} !== {1'b1, NOTEQ, 32'd9, 32'd3}) begin
      n_err++;
      $display("FAIL bne_fwd_mem: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B}, {1'b1, NOTEQ, 32'd9, 32'd3});
    end
    bus.id_valid = 1'b0;
    bus.fwd_a_sel = 2'd2; bus.wb_fwd_data = 32'h11;
    bus.fwd_b_sel = 2'd3; bus.mem_fwd_data = 32'h99;
    #1;
    n_vec++;
    if ({bus.op_A, bus.op_B} !== {32'h11, 32'd3}) begin
      n_err++;
      $display("FAIL bne_fwd_wb_sel3: got %h want %h", {bus.op_A, bus.op_B}, {32'h11, 32'd3});
    end
    bus.fwd_a_sel = 2'd0; bus.fwd_b_sel = 2'd0;
  endtask
  task automatic test_jal();
    drive(1'b1, 32'h0000006F, 32'h100, 32'h20, 32'h7, 32'h8);
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B, bus.ex_pc, bus.ex_pc_plus4} !== {1'b1, JUMP, 32'h100, 32'h20, 32'h100, 32'h104}) begin
      n_err++;
      $display("FAIL jal: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B, bus.ex_pc, bus.ex_pc_plus4}, {1'b1, JUMP, 32'h100, 32'h20, 32'h100, 32'h104});
    end
  endtask
  task automatic test_decode_misc();
    drive(1'b1, 32'h40000013, 32'h0, 32'h30, 32'h4, 32'h5);
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B} !== {1'b1, ADD, 32'h4, 32'h30}) begin
      n_err++;
      $display("FAIL addi_b30: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B}, {1'b1, ADD, 32'h4, 32'h30});
    end
    drive(1'b1, 32'h00000037, 32'h40, 32'hABC00000, 32'h4, 32'h5);
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B} !== {1'b1, ADD, 32'h0, 32'hABC00000}) begin
      n_err++;
      $display("FAIL lui: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B}, {1'b1, ADD, 32'h0, 32'hABC00000});
    end
    drive(1'b1, 32'h40005033, 32'h0, 32'h0, 32'hF0, 32'h2);
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B} !== {1'b1, SRA, 32'hF0, 32'h2}) begin
      n_err++;
      $display("FAIL sra: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B}, {1'b1, SRA, 32'hF0, 32'h2});
    end
    drive(1'b1, 32'h00002063, 32'h0, 32'h0, 32'h1, 32'h2);
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.ex_illegal} !== {1'b1, NOP, 1'b1}) begin
      n_err++;
      $display("FAIL branch_f3_010: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.ex_illegal}, {1'b1, NOP, 1'b1});
    end
    drive(1'b1, 32'h00002023, 32'h0, 32'h8, 32'h1000, 32'h55);
    bus.fwd_b_sel = 2'd2; bus.wb_fwd_data = 32'h66;
    step();
    n_vec++;
    if ({bus.alu_ctrl, bus.op_A, bus.op_B, bus.ex_store_data, bus.ex_illegal} !== {ADD, 32'h1000, 32'h8, 32'h66, 1'b0}) begin
      n_err++;
      $display("FAIL store_fwd: got %h want %h", {bus.alu_ctrl, bus.op_A, bus.op_B, bus.ex_store_data, bus.ex_illegal}, {ADD, 32'h1000, 32'h8, 32'h66, 1'b0});
    end
    bus.fwd_b_sel = 2'd0;
  endtask
  task automatic test_stall_flush();
    drive(1'b1, 32'h00000033, 32'h0, 32'h0, 32'd1, 32'd2);
    step();
    drive(1'b1, 32'h40000033, 32'h0, 32'h0, 32'd8, 32'd2);
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B, bus.id_ready} !== {1'b1, ADD, 32'd1, 32'd2, 1'b0}) begin
        n_err++;
        $display("FAIL stall cycle %0d: got %h want %h", i, {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B, bus.id_ready}, {1'b1, ADD, 32'd1, 32'd2, 1'b0});
      end
    end
    bus.ex_flush = 1'b1;
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B} !== {1'b0, NOP, 64'd0}) begin
      n_err++;
      $display("FAIL stall_flush: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B}, {1'b0, NOP, 64'd0});
    end
    bus.ex_flush = 1'b0; bus.ex_stall = 1'b0; bus.id_valid = 1'b0;
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.id_ready} !== {1'b0, NOP, 1'b1}) begin
      n_err++;
      $display("FAIL bubble: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.id_ready}, {1'b0, NOP, 1'b1});
    end
    bus.id_valid = 1'b1;
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B} !== {1'b1, SUB, 32'd8, 32'd2}) begin
      n_err++;
      $display("FAIL post_flush: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B}, {1'b1, SUB, 32'd8, 32'd2});
    end
  endtask
  task automatic test_custom0();
    logic [69:0] exp;
`ifdef MATRIX_MUL_EN
    exp = {1'b1, MMUL, 32'h12, 32'h34, 1'b0};
`else
    exp = {1'b1, NOP, 32'h12, 32'h34, 1'b1};
`endif
    drive(1'b1, 32'h0000000B, 32'h0, 32'h77, 32'h12, 32'h34);
    step();
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B, bus.ex_illegal} !== exp) begin
      n_err++;
      $display("FAIL custom0: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B, bus.ex_illegal}, exp);
    end
  endtask
  task automatic test_async_reset();
    drive(1'b1, 32'h0000006F, 32'h200, 32'h4, 32'h0, 32'h0);
    step();
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B, bus.ex_pc, bus.ex_pc_plus4} !== {1'b0, NOP, 128'd0}) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", {bus.ex_valid, bus.alu_ctrl, bus.op_A, bus.op_B, bus.ex_pc, bus.ex_pc_plus4}, {1'b0, NOP, 128'd0});
    end
    #2 rstn = 1'b1;
  endtask
  initial begin
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.ex_stall = 1'b0; bus.ex_flush = 1'b0;
    bus.fwd_a_sel = 2'd0; bus.fwd_b_sel = 2'd0;
    bus.mem_fwd_data = 32'h0; bus.wb_fwd_data = 32'h0;
    test_reset();
    test_add_sub();
    test_bne_fwd();
    test_jal();
    test_decode_misc();
    test_stall_flush();
    test_custom0();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
